// File: rtl/apb_timer_seq.sv
// APB-programmed prescaler/counter/comparator sequencer producing a one-cycle trig pulse on match.
// Latency: EN write -> LOAD next edge, COUNT the edge after; APB is zero-wait (PREADY tied 1), no backpressure.
module apb_timer_seq #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [AW-1:0] PADDR,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          trig,
  output logic [DW-1:0] count,
  output logic          running
);

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_PRESC  = AW'(1);
  localparam logic [AW-1:0] A_CMP    = AW'(2);
  localparam logic [AW-1:0] A_STATUS = AW'(3);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_FIRE} state_t;

  typedef struct packed {
    logic          mode;
    logic          en;
    logic [DW-1:0] prescale;
    logic [DW-1:0] compare;
  } cfg_t;

  cfg_t          cfg;
  logic          done;
  state_t        state;
  logic [DW-1:0] pre;
  logic [DW-1:0] cnt;
  logic [DW-1:0] rd_mux;

  logic wr_acc, rd_setup, tick;
  logic wr_ctrl, wr_presc, wr_cmp, wr_status;

  assign wr_acc    = PSEL & PENABLE & PWRITE;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign wr_ctrl   = wr_acc && (PADDR == A_CTRL);
  assign wr_presc  = wr_acc && (PADDR == A_PRESC);
  assign wr_cmp    = wr_acc && (PADDR == A_CMP);
  assign wr_status = wr_acc && (PADDR == A_STATUS);
  assign tick      = (pre == cfg.prescale);

  // Outputs decode straight from the state register so they cannot glitch.
  assign trig    = (state == S_FIRE);
  assign running = (state != S_IDLE);
  assign count   = cnt;
  assign PREADY  = 1'b1;

  // Later assignments take priority: software CTRL write beats the one-shot
  // auto-clear, and the FIRE set of DONE beats a same-cycle clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cfg  <= '0;
      done <= 1'b0;
    end else begin
      if (state == S_FIRE && !cfg.mode)
        cfg.en <= 1'b0;
      if (wr_ctrl) begin
        cfg.en   <= PWDATA[0];
        cfg.mode <= PWDATA[1];
      end
      if (wr_presc)
        cfg.prescale <= PWDATA;
      if (wr_cmp)
        cfg.compare <= PWDATA;
      if (wr_status && PWDATA[0])
        done <= 1'b0;
      if (state == S_FIRE)
        done <= 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= S_IDLE;
      pre   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pre <= '0;
          cnt <= '0;
          if (cfg.en)
            state <= S_LOAD;
        end
        S_LOAD: begin
          pre   <= '0;
          cnt   <= '0;
          state <= cfg.en ? S_COUNT : S_IDLE;
        end
        S_COUNT: begin
          if (!cfg.en) begin
            state <= S_IDLE;
            pre   <= '0;
            cnt   <= '0;
          end else if (tick) begin
            pre <= '0;
            // Equality match only: a COMPARE lowered below cnt wraps through 2^DW.
            if (cnt == cfg.compare)
              state <= S_FIRE;
            else
              cnt <= cnt + DW'(1);
          end else begin
            pre <= pre + DW'(1);
          end
        end
        S_FIRE: begin
          state <= (cfg.mode && cfg.en) ? S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (PADDR)
      A_CTRL: begin
        rd_mux[0] = cfg.en;
        rd_mux[1] = cfg.mode;
      end
      A_PRESC:  rd_mux = cfg.prescale;
      A_CMP:    rd_mux = cfg.compare;
      A_STATUS: begin
        rd_mux[0] = done;
        rd_mux[1] = running;
      end
      default: rd_mux = '0;
    endcase
  end

  // Captured in the setup phase so data is stable for the whole access phase.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      PRDATA <= '0;
    else if (rd_setup)
      PRDATA <= rd_mux;
  end

endmodule

// File: tb/tb_apb_timer_seq.sv
// Directed bench for apb_timer_seq: expected values are queued when stimulus is applied and popped at each check.
module tb_apb_timer_seq;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          trig;
  logic [DW-1:0] count;
  logic          running;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb[$];

  apb_timer_seq #(.DW(DW), .AW(AW)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .trig    (trig),
    .count   (count),
    .running (running)
  );

  always #5 PCLK = ~PCLK;

  task automatic push_exp(input string tag, input logic [DW-1:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic pop_cmp(input logic [DW-1:0] obs);
    sb_t ent;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=0x%0h", obs);
    end else begin
      ent = sb.pop_front();
      assert (obs === ent.exp) else begin
        miscompares++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", ent.tag, obs, ent.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] e);
    push_exp(tag, e);
    pop_cmp(obs);
  endtask

  // Returns at the negedge just after the commit edge.
  task automatic apb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] addr, input logic [DW-1:0] e, input string tag);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    push_exp($sformatf("%s_a%0d", tag, addr), e);
    @(negedge PCLK);
    PENABLE = 1'b1;
    pop_cmp(PRDATA);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    #1;
    chk("rst_trig",    DW'(trig),    8'h00);
    chk("rst_running", DW'(running), 8'h00);
    chk("rst_count",   count,        8'h00);
    chk("rst_prdata",  PRDATA,       8'h00);
    chk("pready",      DW'(PREADY),  8'h01);
    cycles(2);
    PRESET = 1'b0;
    for (int a = 0; a < 4; a++) apb_read(AW'(a), 8'h00, "rst_reg");

    // One-shot: PRESCALE=0, COMPARE=3 -> FIRE 6 cycles after the EN write.
    apb_write(2'd1, 8'd0);
    apb_write(2'd2, 8'd3);
    apb_write(2'd0, 8'h01);
    for (int k = 1; k <= 9; k++) begin
      @(negedge PCLK);
      chk($sformatf("os_trig_k%0d", k), DW'(trig), DW'(k == 6));
      chk($sformatf("os_running_k%0d", k), DW'(running), DW'(k <= 6));
      if (k >= 2 && k <= 5) chk($sformatf("os_count_k%0d", k), count, DW'(k - 2));
    end
    apb_read(2'd3, 8'h01, "os_status");
    apb_read(2'd0, 8'h00, "os_ctrl");

    // Periodic: PRESCALE=2, COMPARE=1 -> 6 COUNT cycles, FIRE, LOAD; period 8.
    apb_write(2'd1, 8'd2);
    apb_write(2'd2, 8'd1);
    apb_write(2'd0, 8'h03);
    for (int k = 1; k <= 26; k++) begin
      int j;
      @(negedge PCLK);
      j = (k >= 2) ? (k - 2) % 8 : 7;
      chk($sformatf("per_trig_k%0d", k), DW'(trig), DW'(k >= 2 && j == 6));
      chk($sformatf("per_running_k%0d", k), DW'(running), 8'h01);
      if (k >= 2 && j < 6) chk($sformatf("per_count_k%0d", k), count, DW'(j / 3));
    end

    // Stop mid-COUNT: write commits three edges after the loop ends (j=3).
    apb_write(2'd0, 8'h02);
    chk("stop_running_commit", DW'(running), 8'h01);
    @(negedge PCLK);
    chk("stop_running", DW'(running), 8'h00);
    chk("stop_count",   count,        8'h00);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      chk("stop_no_trig", DW'(trig), 8'h00);
    end
    apb_read(2'd3, 8'h01, "stop_status");
    apb_read(2'd0, 8'h02, "stop_ctrl");

    // DONE clear, then a clear write colliding with FIRE: set wins.
    apb_write(2'd3, 8'h01);
    apb_read(2'd3, 8'h00, "clr_status");
    apb_write(2'd1, 8'd0);
    apb_write(2'd2, 8'd3);
    apb_write(2'd0, 8'h01);
    cycles(4);
    apb_write(2'd3, 8'h01);
    apb_read(2'd3, 8'h01, "fire_clr_status");
    apb_write(2'd3, 8'h01);
    apb_read(2'd3, 8'h00, "late_clr_status");

    // CTRL write on the one-shot auto-clear edge keeps EN set.
    apb_write(2'd0, 8'h01);
    cycles(4);
    apb_write(2'd0, 8'h01);
    chk("sw_wins_idle", DW'(running), 8'h00);
    @(negedge PCLK);
    chk("sw_wins_load", DW'(running), 8'h01);
    cycles(5);
    chk("sw_wins_trig", DW'(trig), 8'h01);
    cycles(3);
    chk("sw_wins_done_running", DW'(running), 8'h00);
    apb_read(2'd0, 8'h00, "sw_wins_ctrl");

    // Reset while counting with count=5.
    apb_write(2'd2, 8'd10);
    apb_write(2'd0, 8'h03);
    cycles(7);
    chk("pre_rst_count", count, 8'd5);
    #2 PRESET = 1'b1;
    #1;
    chk("mid_rst_trig",    DW'(trig),    8'h00);
    chk("mid_rst_count",   count,        8'h00);
    chk("mid_rst_running", DW'(running), 8'h00);
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int a = 0; a < 4; a++) apb_read(AW'(a), 8'h00, "post_rst_reg");
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      chk("post_rst_running", DW'(running), 8'h00);
      chk("post_rst_count",   count,        8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
